// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO write domain.
// Grants one requester per burst of up to MAX_BURST beats, then rotates.
module fifo_wr_arbiter #(
   parameter int N         = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4,
   parameter int CW        = $clog2(MAX_BURST + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req,
   input  logic [N*WIDTH-1:0] req_data,
   input  logic               fifo_full,
   output logic [N-1:0]       gnt,
   output logic [N-1:0]       ack,
   output logic               fifo_we,
   output logic [WIDTH-1:0]   fifo_din,
   output logic               busy
);

   localparam int OW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE,
      XFER
   } state_t;

   state_t          state;
   logic [OW-1:0]   owner;
   logic [OW-1:0]   pick;
   logic [CW-1:0]   beat_cnt;
   logic [N-1:0]    one;
   logic            xfer;
   logic            own_req;
   logic            beat;
   logic            last;
   logic            done;
   int              idx;
   logic            found;

   assign one = {{(N-1){1'b0}}, 1'b1};

   // Search owner+1, owner+2, ... wrapping, so the last owner goes last.
   always_comb begin
      pick  = owner;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N; k++) begin
         idx = int'(owner) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx[OW-1:0]]) begin
            pick  = idx[OW-1:0];
            found = 1'b1;
         end
      end
   end

   assign xfer     = (state == XFER);
   assign own_req  = req[owner];
   assign beat     = xfer & own_req & ~fifo_full;
   assign last     = (beat_cnt == CW'(MAX_BURST - 1));
   assign done     = xfer & (~own_req | (beat & last));
   assign fifo_we  = beat;
   assign ack      = beat ? gnt : '0;
   assign busy     = xfer;
   assign fifo_din = xfer ? req_data[owner*WIDTH +: WIDTH] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         gnt      <= '0;
         owner    <= OW'(N - 1);
         beat_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|req) begin
                  owner    <= pick;
                  gnt      <= one << pick;
                  beat_cnt <= '0;
                  state    <= XFER;
               end
            end
            XFER: begin
               if (done) begin
                  gnt   <= '0;
                  state <= IDLE;
               end else if (beat) begin
                  beat_cnt <= beat_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: bursts, rotation, stalls, reset.
// A second instance with MAX_BURST=1 covers single-beat alternation.
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic        fifo_full;

   logic [3:0]  gnt, ack;
   logic        fifo_we, busy;
   logic [7:0]  fifo_din;

   logic [3:0]  gnt1, ack1;
   logic        fifo_we1, busy1;
   logic [7:0]  fifo_din1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.N(4), .WIDTH(8), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .fifo_full(fifo_full), .gnt(gnt), .ack(ack),
      .fifo_we(fifo_we), .fifo_din(fifo_din), .busy(busy)
   );

   fifo_wr_arbiter #(.N(4), .WIDTH(8), .MAX_BURST(1)) dut1 (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .fifo_full(fifo_full), .gnt(gnt1), .ack(ack1),
      .fifo_we(fifo_we1), .fifo_din(fifo_din1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      rst       = 1'b0;
      req       = '0;
      fifo_full = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   logic [3:0] oh;
   int         seq [5];

   initial begin
      rst       = 1'b0;
      req       = '0;
      fifo_full = 1'b0;
      req_data  = 32'hD3D2D1D0;
      #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_we", 32'(fifo_we), 32'h0);
      chk("rst_din", 32'(fifo_din), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);

      // 1: single requester, three beats then drop
      do_reset();
      req = 4'b0100;
      #1;
      chk("t1_idle_gnt", 32'(gnt), 32'h0);
      for (int b = 0; b < 3; b++) begin
         tick();
         #1;
         chk("t1_gnt", 32'(gnt), 32'h4);
         chk("t1_we", 32'(fifo_we), 32'h1);
         chk("t1_ack", 32'(ack), 32'h4);
         chk("t1_din", 32'(fifo_din), 32'hD2);
      end
      tick();
      req = 4'b0000;
      #1;
      chk("t1_drop_we", 32'(fifo_we), 32'h0);
      chk("t1_drop_gnt", 32'(gnt), 32'h4);
      tick();
      #1;
      chk("t1_rel_gnt", 32'(gnt), 32'h0);
      chk("t1_rel_busy", 32'(busy), 32'h0);

      // 2: all requesting, bursts of 4 rotate 0,1,2,3,0
      do_reset();
      req = 4'b1111;
      seq = '{0, 1, 2, 3, 0};
      for (int s = 0; s < 5; s++) begin
         oh = 4'b0001 << seq[s];
         for (int b = 0; b < 4; b++) begin
            tick();
            #1;
            chk("t2_gnt", 32'(gnt), 32'(oh));
            chk("t2_ack", 32'(ack), 32'(oh));
            chk("t2_din", 32'(fifo_din), 32'(8'hD0 + seq[s]));
         end
         tick();
         #1;
         chk("t2_gap_gnt", 32'(gnt), 32'h0);
         chk("t2_gap_we", 32'(fifo_we), 32'h0);
      end

      // 3: owner 1 stalls by full after 2 beats, then 2 more beats
      do_reset();
      req = 4'b0010;
      for (int b = 0; b < 2; b++) begin
         tick();
         #1;
         chk("t3_pre_we", 32'(fifo_we), 32'h1);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         fifo_full = 1'b1;
         #1;
         chk("t3_stall_we", 32'(fifo_we), 32'h0);
         chk("t3_stall_ack", 32'(ack), 32'h0);
         chk("t3_stall_gnt", 32'(gnt), 32'h2);
      end
      for (int b = 0; b < 2; b++) begin
         tick();
         fifo_full = 1'b0;
         #1;
         chk("t3_post_we", 32'(fifo_we), 32'h1);
         chk("t3_post_din", 32'(fifo_din), 32'hD1);
      end
      tick();
      #1;
      chk("t3_rel_gnt", 32'(gnt), 32'h0);
      chk("t3_rel_we", 32'(fifo_we), 32'h0);

      // 4: owner 3 full, drops req; wrap search picks 1
      do_reset();
      req       = 4'b1000;
      fifo_full = 1'b1;
      tick();
      #1;
      chk("t4_gnt3", 32'(gnt), 32'h8);
      chk("t4_full_we", 32'(fifo_we), 32'h0);
      tick();
      req = 4'b0010;
      #1;
      chk("t4_drop_we", 32'(fifo_we), 32'h0);
      chk("t4_drop_ack", 32'(ack), 32'h0);
      tick();
      #1;
      chk("t4_idle_gnt", 32'(gnt), 32'h0);
      tick();
      #1;
      chk("t4_gnt1", 32'(gnt), 32'h2);
      chk("t4_gnt1_we", 32'(fifo_we), 32'h0);
      fifo_full = 1'b0;
      #1;
      chk("t4_we", 32'(fifo_we), 32'h1);
      chk("t4_din", 32'(fifo_din), 32'hD1);

      // 5: async reset mid-burst, then first grant is requester 0
      do_reset();
      req = 4'b1111;
      tick();
      #1;
      chk("t5_gnt0", 32'(gnt), 32'h1);
      chk("t5_we", 32'(fifo_we), 32'h1);
      #1;
      rst = 1'b0;
      #1;
      chk("t5_rst_gnt", 32'(gnt), 32'h0);
      chk("t5_rst_we", 32'(fifo_we), 32'h0);
      chk("t5_rst_ack", 32'(ack), 32'h0);
      chk("t5_rst_busy", 32'(busy), 32'h0);
      #1;
      rst = 1'b1;
      tick();
      #1;
      chk("t5_first_gnt", 32'(gnt), 32'h1);

      // 6: MAX_BURST=1 instance alternates 1,3,1,3
      do_reset();
      req = 4'b1010;
      for (int s = 0; s < 4; s++) begin
         oh = (s % 2 == 0) ? 4'b0010 : 4'b1000;
         tick();
         #1;
         chk("t6_gnt", 32'(gnt1), 32'(oh));
         chk("t6_we", 32'(fifo_we1), 32'h1);
         chk("t6_ack", 32'(ack1), 32'(oh));
         tick();
         #1;
         chk("t6_gap_gnt", 32'(gnt1), 32'h0);
         chk("t6_gap_we", 32'(fifo_we1), 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
